// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
// A FIFO entry pairs a returned instruction word with the PC it was fetched from.
package instr_fetch_pkg;

    localparam int unsigned wd_regs_c = 32;
    localparam logic [wd_regs_c-1:0] reset_pc_c = '0;

    typedef struct packed {
        logic [wd_regs_c-1:0] instr;
        logic [wd_regs_c-1:0] pc;
    } fetch_entry_t;

    function automatic logic [wd_regs_c-1:0] word_align(input logic [wd_regs_c-1:0] addr);
        return {addr[wd_regs_c-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Bus bundle of the fetch unit: redirect input, imem request/response, decode output.
// A valid/ready channel transfers exactly on a cycle where both are high; valid and its payload
// hold until that cycle (the fetch request may only drop early on a redirect); the response
// channel has no ready and must be consumed the cycle it is valid.
interface instr_fetch_if #(
    parameter int unsigned wd = 32
);
    logic          i_redirect;
    logic [wd-1:0] i_redirect_pc;
    logic          o_imem_req_valid;
    logic          i_imem_req_ready;
    logic [wd-1:0] o_imem_addr;
    logic          i_imem_rsp_valid;
    logic [wd-1:0] i_imem_rsp_data;
    logic          o_instr_valid;
    logic          i_instr_ready;
    logic [wd-1:0] o_instr;
    logic [wd-1:0] o_instr_pc;

    modport master (
        input  i_redirect, i_redirect_pc, i_imem_req_ready, i_imem_rsp_valid,
               i_imem_rsp_data, i_instr_ready,
        output o_imem_req_valid, o_imem_addr, o_instr_valid, o_instr, o_instr_pc
    );

    modport slave (
        output i_redirect, i_redirect_pc, i_imem_req_ready, i_imem_rsp_valid,
               i_imem_rsp_data, i_instr_ready,
        input  o_imem_req_valid, o_imem_addr, o_instr_valid, o_instr, o_instr_pc
    );
endinterface

// File: rtl/instr_fetch_sync_fifo.sv
// Synchronous FIFO with flush and occupancy count; head is valid whenever count is non-zero.
// Push into a full FIFO and pop from an empty one are ignored.
module instr_fetch_sync_fifo #(
    parameter int unsigned width_p = 64,
    parameter int unsigned depth_p = 4,
    localparam int unsigned addr_w = $clog2(depth_p),
    localparam int unsigned cnt_w  = $clog2(depth_p) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               push,
    input  logic [width_p-1:0] push_data,
    input  logic               pop,
    output logic [width_p-1:0] head,
    output logic [cnt_w-1:0]   count
);

    logic [width_p-1:0] mem [depth_p];
    logic [addr_w-1:0]  wr_ptr;
    logic [addr_w-1:0]  rd_ptr;
    logic               do_push;
    logic               do_pop;

    assign do_push = push && (count != cnt_w'(depth_p));
    assign do_pop  = pop && (count != '0);
    assign head    = mem[rd_ptr];

    // Storage is cleared only on reset so the head reads zero out of reset; a flush just rewinds.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            mem    <= '{default: '0};
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + addr_w'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + addr_w'(1);
            end
            count <= count + cnt_w'(do_push) - cnt_w'(do_pop);
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Fetch PC unit: issues word fetches under a credit limit, buffers responses with their PCs,
// and on redirect flushes the buffer and drops responses still in flight.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int unsigned          wd_regs_p   = wd_regs_c,
    parameter logic [wd_regs_p-1:0] reset_pc_p  = reset_pc_c,
    parameter int unsigned          buf_depth_p = 4
) (
    input  logic          clk,
    input  logic          rst,
    instr_fetch_if.master bus
);

    localparam int unsigned    cnt_w   = $clog2(buf_depth_p) + 1;
    localparam logic [cnt_w:0] depth_c = (cnt_w + 1)'(buf_depth_p);

    logic [wd_regs_p-1:0] fetch_pc;
    logic [wd_regs_p-1:0] rsp_pc;
    logic [cnt_w-1:0]     outstanding;
    logic [cnt_w-1:0]     discard;
    logic [cnt_w-1:0]     fifo_count;
    logic [cnt_w-1:0]     outstanding_after_rsp;
    logic [cnt_w:0]       in_flight;
    logic                 run_q;
    logic                 req_valid;
    logic                 req_fire;
    logic                 rsp_keep;
    fetch_entry_t         push_entry;
    fetch_entry_t         head_entry;

    // Requests plus buffered entries never exceed the FIFO depth, so every response has a slot.
    assign in_flight = {1'b0, outstanding} + {1'b0, fifo_count};
    assign req_valid = run_q && (in_flight < depth_c) && (discard == '0) && !bus.i_redirect;
    assign req_fire  = req_valid && bus.i_imem_req_ready;
    assign rsp_keep  = bus.i_imem_rsp_valid && (discard == '0) && !bus.i_redirect;

    assign outstanding_after_rsp = outstanding - cnt_w'(bus.i_imem_rsp_valid);

    assign bus.o_imem_req_valid = req_valid;
    assign bus.o_imem_addr      = fetch_pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= reset_pc_p;
            rsp_pc      <= reset_pc_p;
            outstanding <= '0;
            discard     <= '0;
            run_q       <= 1'b0;
        end else begin
            run_q       <= 1'b1;
            outstanding <= outstanding_after_rsp + cnt_w'(req_fire);
            if (bus.i_redirect) begin
                fetch_pc <= word_align(bus.i_redirect_pc);
                rsp_pc   <= word_align(bus.i_redirect_pc);
                discard  <= outstanding_after_rsp;
            end else begin
                if (req_fire) begin
                    fetch_pc <= fetch_pc + wd_regs_p'(4);
                end
                if (bus.i_imem_rsp_valid) begin
                    if (discard != '0) begin
                        discard <= discard - cnt_w'(1);
                    end else begin
                        rsp_pc <= rsp_pc + wd_regs_p'(4);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (fifo_count <= cnt_w'(buf_depth_p));
            assert (outstanding <= cnt_w'(buf_depth_p));
        end
    end

    assign push_entry = '{instr: bus.i_imem_rsp_data, pc: rsp_pc};

    instr_fetch_sync_fifo #(
        .width_p ($bits(fetch_entry_t)),
        .depth_p (buf_depth_p)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (bus.i_redirect),
        .push      (rsp_keep),
        .push_data (push_entry),
        .pop       (bus.o_instr_valid && bus.i_instr_ready),
        .head      (head_entry),
        .count     (fifo_count)
    );

    assign bus.o_instr_valid = (fifo_count != '0);
    assign bus.o_instr       = head_entry.instr;
    assign bus.o_instr_pc    = head_entry.pc;

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Front-end PC/fetch unit; the consumer of the branch unit's redirect outputs (target PC plus taken strobe).
- Holds the architectural fetch PC and issues word fetches to instruction memory over a valid/ready request channel with an in-order response channel.
- Buffers returned instructions with their PCs in a small FIFO and presents them to decode with valid/ready.
- On redirect: flushes the buffer, discards in-flight responses, restarts fetch at the target.

Parameters:
- wd_regs_p, 32, PC/address and instruction width.
- reset_pc_p, 32'h0000_0000, fetch PC after reset.
- buf_depth_p, 4, instruction FIFO entries (power of 2, >=2).

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  synchronous reset, active-high
- i_redirect  input  1  branch/jump taken; load new PC
- i_redirect_pc  input  wd_regs_p  redirect target; bits [1:0] forced to 0
- o_imem_req_valid  output  1  fetch request valid
- i_imem_req_ready  input  1  memory accepts request
- o_imem_addr  output  wd_regs_p  fetch address (word aligned)
- i_imem_rsp_valid  input  1  response valid (in order, one per accepted request, no backpressure)
- i_imem_rsp_data  input  wd_regs_p  fetched instruction word
- o_instr_valid  output  1  instruction available to decode
- i_instr_ready  input  1  decode accepts instruction
- o_instr  output  wd_regs_p  instruction word (FIFO head)
- o_instr_pc  output  wd_regs_p  PC of o_instr

Behaviour:
- Reset (rst=1 at edge):
  - fetch_pc=reset_pc_p, rsp_pc=reset_pc_p.
  - outstanding=0, discard=0, FIFO empty.
  - o_imem_req_valid=0, o_instr_valid=0.
  - o_imem_addr=reset_pc_p, o_instr=0, o_instr_pc=0.
  - Reset mid-operation drops everything; responses arriving after reset to pre-reset requests are the memory's responsibility (memory is reset together).
- Request issue:
  - o_imem_req_valid=1 when (outstanding + fifo_count) < buf_depth_p and discard==0 and !i_redirect.
  - o_imem_addr=fetch_pc.
  - Handshake = valid&ready: fetch_pc += 4 (wraps mod 2^wd_regs_p), outstanding += 1.
  - Valid/addr stay stable until accepted unless a redirect occurs.
  - The credit rule guarantees every response has FIFO space; a response never overflows.
- Response:
  - On i_imem_rsp_valid: outstanding -= 1.
  - If discard>0: discard -= 1, data dropped.
  - Else: push {i_imem_rsp_data, rsp_pc} into the FIFO, rsp_pc += 4.
  - Request accept and response in the same cycle leave outstanding unchanged.
- Output:
  - o_instr_valid = FIFO non-empty; o_instr/o_instr_pc = head entry.
  - Pop on valid&ready.
  - Zero-latency bypass is not provided: an instruction is visible the cycle after its response.
- Redirect (i_redirect=1), highest priority:
  - Next cycle: fetch_pc=rsp_pc=i_redirect_pc&~3, FIFO cleared, o_instr_valid=0.
  - discard = outstanding minus (1 if a response arrives this cycle).
  - o_imem_req_valid forced 0 in the redirect cycle; no request is accepted that cycle.
  - A decode pop in the same cycle is ignored (entry flushed anyway).
- Discard:
  - No new requests while discard>0.
  - Fetch resumes the cycle after discard reaches 0.
- Back-to-back redirects: each recomputes discard from current outstanding; the last target wins.
- Overflow impossible by construction: assertion fifo_count<=buf_depth_p, outstanding<=buf_depth_p.
- Latency: redirect cycle N -> first request at the new PC at N+1 if outstanding==0.

Decomposition:
- Package: fetch_entry_t struct {instr, pc} and the default PC constant.
- Natural sub-module: sync_fifo (parameterised width/depth, push/pop/flush, count output), reused for fetch_entry_t.
- Top holds the PC, credit and discard counters.

Test Plan:
1. Reset then memory always ready, 1-cycle response, decode always ready -> requests at 0x0,0x4,0x8..., o_instr_pc sequence 0x0,0x4,0x8 matching data, one instruction per cycle steady state.
2. Decode holds i_instr_ready=0 -> exactly buf_depth_p=4 requests issued, then req_valid=0; after ready=1, the FIFO drains in order and fetch resumes at 0x10.
3. Redirect to 0x100 with 2 requests outstanding (3-cycle memory latency) -> next two responses dropped, FIFO empty, first request after discard at 0x100, next o_instr_pc=0x100.
4. Redirect to 0x203 -> fetch address 0x200, o_instr_pc 0x200.
5. Redirect in the same cycle as a response and a decode pop -> response dropped, discard correct, no stale instruction emitted.
6. Assert rst mid-stream with FIFO full -> next cycle all outputs at reset values, fetch restarts at reset_pc_p; fetch_pc at 0xFFFF_FFFC increments and wraps to 0x0.
